image_stream_tx: RTL

- Frame-memory reader that streams a stored grayscale image as raster-order pixels over a valid/ready interface.
- Carries start-of-frame, end-of-line and end-of-frame markers.
- It is the transmit end of the pixel stream that the Sobel line-buffer filter consumes, and replaces file-loaded image arrays with a real streaming source.
- Sits between the frame RAM (synchronous read port) and the filter's pixel input.

---
 rtl/image_stream_pkg.sv | 34 +++
 rtl/stream_skid_fifo.sv | 54 +++++
 rtl/image_stream_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/image_stream_pkg.sv
// Shared types and default geometry for the image stream transmitter and the Sobel filter.
// FSM encoding, FIFO entry layout and a counter-width helper live here.
package image_stream_pkg;

  localparam int DEF_IMAGE_WIDTH  = 512;
  localparam int DEF_IMAGE_HEIGHT = 512;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_ADDR_WIDTH   = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_marks_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      sof;
    logic                      eol;
    logic                      eof;
  } pix_entry_t;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO with occupancy count; head is read straight from the storage registers.
// Push and pop on a full FIFO in the same cycle are accepted and leave occupancy unchanged.
module stream_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] slot_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      // When full, wr_ptr equals rd_ptr, so a simultaneous push overwrites the entry leaving now.
      if (do_push) begin
        slot_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = slot_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/image_stream_tx.sv
// Reads a stored frame from a synchronous-read RAM and streams it in raster order with sof/eol/eof.
// Define IMAGE_STREAM_TX_BORDER_PAD_EN to wrap the frame in a one-pixel zero border.
module image_stream_tx
  import image_stream_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof
);

`ifdef IMAGE_STREAM_TX_BORDER_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int GW = IMAGE_WIDTH + 2 * PAD;
  localparam int GH = IMAGE_HEIGHT + 2 * PAD;
  localparam int CW = ctr_width(GW);
  localparam int RW = ctr_width(GH);
  localparam int EW = DATA_WIDTH + $bits(pix_marks_t);
  localparam logic [CW-1:0]         COL_LAST  = CW'(GW - 1);
  localparam logic [RW-1:0]         ROW_LAST  = RW'(GH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

  tx_state_e             state_q;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  slot_pend_q;
  logic                  pad_pend_q;
  pix_marks_t            marks_pend_q;

  logic                  col_last;
  logic                  row_last;
  logic                  is_pad;
  logic                  issue;
  logic                  pop;
  logic [2:0]            occupancy;
  pix_marks_t            issue_marks;
  pix_marks_t            head_marks;
  logic [1:0]            fifo_count;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] push_pix;
  logic [DATA_WIDTH-1:0] head_pix;
  logic [EW-1:0]         push_entry;
  logic [EW-1:0]         head_entry;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

`ifdef IMAGE_STREAM_TX_BORDER_PAD_EN
  assign is_pad = (col_q == '0) || col_last || (row_q == '0) || row_last;
`else
  assign is_pad = 1'b0;
`endif

  // A slot is issued only if it will still fit once everything already in flight has landed.
  assign pop       = fifo_valid & pix_ready;
  assign occupancy = 3'(fifo_count) + 3'(slot_pend_q) - 3'(pop);
  assign issue     = (state_q == ST_RUN) && (occupancy < 3'd2);

  assign issue_marks.sof = (col_q == '0) && (row_q == '0);
  assign issue_marks.eol = col_last;
  assign issue_marks.eof = col_last && row_last;

  assign mem_rd_en   = issue & ~is_pad;
  assign mem_rd_addr = addr_q;

  assign push_pix   = pad_pend_q ? '0 : mem_rd_data;
  assign push_entry = {push_pix, marks_pend_q};
  assign {head_pix, head_marks} = head_entry;

  stream_skid_fifo #(
    .WIDTH(EW)
  ) u_fifo (
    .clk        (clk),
    .rst_ni     (reset),
    .push_i     (slot_pend_q),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .head_o     (head_entry),
    .valid_o    (fifo_valid),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      slot_pend_q  <= 1'b0;
      pad_pend_q   <= 1'b0;
      marks_pend_q <= '0;
    end else begin
      done_q       <= 1'b0;
      slot_pend_q  <= issue;
      pad_pend_q   <= issue & is_pad;
      marks_pend_q <= issue_marks;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (!is_pad && (addr_q != ADDR_LAST)) begin
              addr_q <= addr_q + 1'b1;
            end
            if (col_last) begin
              col_q <= '0;
              if (row_last) begin
                state_q <= ST_DRAIN;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head_marks.eof) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_valid = fifo_valid;
  assign pix_data  = head_pix;
  assign pix_sof   = fifo_valid & head_marks.sof;
  assign pix_eol   = fifo_valid & head_marks.eol;
  assign pix_eof   = fifo_valid & head_marks.eof;

endmodule
